// File: rtl/srlatch_ctrl_pkg.sv
// Shared definitions for the SR latch controller.
//   state_t  : FSM state encoding (IDLE, PULSE, GAP, CHECK)
//   OP_SET   : requester op value that drives the latch set input
//   OP_RESET : requester op value that drives the latch reset input
package srlatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   req[1:0] : request vector, bit 0 = A, bit 1 = B
//   advance  : a grant is being taken this cycle; priority moves on
//   gnt[1:0] : one-hot combinational grant (zero when no request)
// After reset requester A has priority. Priority only moves when a grant
// is actually taken, and it then favours the requester not just served.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1: B wins a tie, 0: A wins a tie
  logic prio_b;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !prio_b)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_b <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      // Serving A hands the next tie to B, and vice versa.
      prio_b <= gnt[0];
    end
  end

endmodule

// File: rtl/srlatch_ctrl.sv
// Controller sharing one external NAND SR latch between two requesters.
// Each operation drives a fixed-width active-low pulse on s_n (set) or
// r_n (reset), waits a recovery gap with both inputs high, then compares
// the synchronised latch output against the requested value.
// Ports:
//   clk, rst           : clock and asynchronous active-high reset
//   req_a, op_a, gnt_a : requester A (level request, op 1=set, 1-cycle grant)
//   req_b, op_b, gnt_b : requester B
//   s_n, r_n           : active-low latch set / reset, never low together
//   q_in               : asynchronous latch Q feedback
//   q_exp              : expected latch state after the last completed op
//   busy               : high outside IDLE
//   done               : one-cycle pulse while in CHECK
//   mismatch           : latch disagreed with q_exp at the last CHECK
module srlatch_ctrl
  import srlatch_ctrl_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 3,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic op_a,
  output logic gnt_a,
  input  logic req_b,
  input  logic op_b,
  output logic gnt_b,
  output logic s_n,
  output logic r_n,
  input  logic q_in,
  output logic q_exp,
  output logic busy,
  output logic done,
  output logic mismatch
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             op_r, op_r_d;
  logic             s_n_d, r_n_d;
  logic             gnt_a_d, gnt_b_d;
  logic             busy_d, done_d;
  logic             q_exp_d, mismatch_d;
  logic             sel_op;
  logic             q_meta, q_sync;
  logic [1:0]       arb_gnt;
  logic             in_idle;

  assign in_idle = (state == ST_IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req_b, req_a}),
    .advance (in_idle),
    .gnt     (arb_gnt)
  );

  // q_in is asynchronous to clk; only q_sync may be used by the logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_meta <= 1'b0;
      q_sync <= 1'b0;
    end else begin
      q_meta <= q_in;
      q_sync <= q_meta;
    end
  end

  // NOTE: every signal is given a default before the case statement so no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    op_r_d     = op_r;
    s_n_d      = 1'b1;
    r_n_d      = 1'b1;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    done_d     = 1'b0;
    q_exp_d    = q_exp;
    mismatch_d = mismatch;
    sel_op     = arb_gnt[0] ? op_a : op_b;

    unique case (state)
      ST_IDLE: begin
        if (arb_gnt != 2'b00) begin
          op_r_d  = sel_op;
          gnt_a_d = arb_gnt[0];
          gnt_b_d = arb_gnt[1];
          s_n_d   = (sel_op != OP_SET);
          r_n_d   = (sel_op == OP_SET);
          cnt_d   = PULSE_LOAD;
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          // Both inputs return high together; the defaults already do that.
          cnt_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else begin
          s_n_d = (op_r != OP_SET);
          r_n_d = (op_r == OP_SET);
          cnt_d = cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          // Result registers update on entry so they are valid alongside done.
          done_d     = 1'b1;
          q_exp_d    = op_r;
          mismatch_d = (q_sync != op_r);
          state_d    = ST_CHECK;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_r     <= OP_RESET;
      s_n      <= 1'b1;
      r_n      <= 1'b1;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      q_exp    <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      op_r     <= op_r_d;
      s_n      <= s_n_d;
      r_n      <= r_n_d;
      gnt_a    <= gnt_a_d;
      gnt_b    <= gnt_b_d;
      busy     <= busy_d;
      done     <= done_d;
      q_exp    <= q_exp_d;
      mismatch <= mismatch_d;
    end
  end

endmodule

// File: tb/tb_srlatch_ctrl.sv
// Directed bench for srlatch_ctrl. Two instances share clock and reset:
// dut uses PULSE_W=2/GAP_W=3, dut1 uses PULSE_W=1/GAP_W=3. Each drives a
// behavioural NAND SR latch model whose Q feeds back into q_in.
module tb_srlatch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic req_a = 1'b0, op_a = 1'b0, req_b = 1'b0, op_b = 1'b0;
  logic gnt_a, gnt_b, s_n, r_n, q_in, q_exp, busy, done, mismatch;

  logic req_a1 = 1'b0, op_a1 = 1'b0, req_b1 = 1'b0, op_b1 = 1'b0;
  logic gnt_a1, gnt_b1, s_n1, r_n1, q_in1, q_exp1, busy1, done1, mismatch1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  srlatch_ctrl #(.PULSE_W(2), .GAP_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .op_a(op_a), .gnt_a(gnt_a),
    .req_b(req_b), .op_b(op_b), .gnt_b(gnt_b),
    .s_n(s_n), .r_n(r_n), .q_in(q_in), .q_exp(q_exp),
    .busy(busy), .done(done), .mismatch(mismatch)
  );

  srlatch_ctrl #(.PULSE_W(1), .GAP_W(3), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst),
    .req_a(req_a1), .op_a(op_a1), .gnt_a(gnt_a1),
    .req_b(req_b1), .op_b(op_b1), .gnt_b(gnt_b1),
    .s_n(s_n1), .r_n(r_n1), .q_in(q_in1), .q_exp(q_exp1),
    .busy(busy1), .done(done1), .mismatch(mismatch1)
  );

  // NAND SR latch models; stuck forces the fed-back Q of dut to 0.
  logic q_lat = 1'b0, q_lat1 = 1'b0, stuck = 1'b0;
  always @(s_n or r_n) begin
    if (s_n === 1'b0) q_lat = 1'b1;
    else if (r_n === 1'b0) q_lat = 1'b0;
  end
  always @(s_n1 or r_n1) begin
    if (s_n1 === 1'b0) q_lat1 = 1'b1;
    else if (r_n1 === 1'b0) q_lat1 = 1'b0;
  end
  assign q_in  = stuck ? 1'b0 : q_lat;
  assign q_in1 = q_lat1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Cycles until the next grant of dut; n counts edges from the call.
  task automatic wait_grant(input string tag, output int n);
    n = 0;
    do begin tick(); n++; end while (!(gnt_a || gnt_b) && n < 40);
    check(tag, {31'b0, gnt_a | gnt_b}, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin tick(); n++; end while (!done && n < 40);
    check(tag, {31'b0, done}, 1);
  endtask

  // Per-cycle protocol monitor for the random phase.
  bit mon_en = 1'b0;
  int run_lo = 0, run_hi = 0;
  bit seen_pulse = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("no_overlap", {31'b0, s_n | r_n}, 1);
      if (!s_n || !r_n) begin
        if (run_lo == 0 && seen_pulse) check("gap_ge3", {31'b0, run_hi >= 3}, 1);
        run_lo++;
        run_hi = 0;
      end else begin
        if (run_lo != 0) begin
          check("pulse_len", run_lo, 2);
          seen_pulse = 1'b1;
        end
        run_lo = 0;
        run_hi++;
      end
    end
  end

  initial begin
    int n;
    int p;
    logic exp_q;

    // ---- Test 1: reset values and a single set from A ----
    do_reset();
    check("rst_s_n", {31'b0, s_n}, 1);
    check("rst_r_n", {31'b0, r_n}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_q_exp", {31'b0, q_exp}, 0);
    check("rst_mismatch", {31'b0, mismatch}, 0);
    check("rst_gnt", {30'b0, gnt_b, gnt_a}, 0);

    req_a = 1'b1; op_a = 1'b1;
    tick();                                   // t0
    check("t1_gnt_a", {31'b0, gnt_a}, 1);
    check("t1_s_n_t0", {31'b0, s_n}, 0);
    check("t1_r_n_t0", {31'b0, r_n}, 1);
    check("t1_busy", {31'b0, busy}, 1);
    req_a = 1'b0;
    tick();                                   // t0+1
    check("t1_gnt_one_cycle", {31'b0, gnt_a}, 0);
    check("t1_s_n_t1", {31'b0, s_n}, 0);
    tick();                                   // t0+2
    check("t1_s_n_t2", {31'b0, s_n}, 1);
    check("t1_r_n_t2", {31'b0, r_n}, 1);
    tick();                                   // t0+3
    tick();                                   // t0+4
    check("t1_done_early", {31'b0, done}, 0);
    tick();                                   // t0+5
    check("t1_done", {31'b0, done}, 1);
    check("t1_q_exp", {31'b0, q_exp}, 1);
    check("t1_mismatch", {31'b0, mismatch}, 0);
    tick();                                   // t0+6
    check("t1_done_pulse", {31'b0, done}, 0);
    check("t1_busy_end", {31'b0, busy}, 0);

    // ---- Test 2: both requesting, alternating grants ----
    do_reset();
    req_a = 1'b1; op_a = 1'b1; req_b = 1'b1; op_b = 1'b0;
    tick();
    check("t2_first_a", {30'b0, gnt_b, gnt_a}, 2'b01);
    wait_grant("t2_grant_b_seen", n);
    check("t2_gap7", n, 7);
    check("t2_second_b", {30'b0, gnt_b, gnt_a}, 2'b10);
    check("t2_r_n_low", {31'b0, r_n}, 0);
    check("t2_s_n_high", {31'b0, s_n}, 1);
    wait_grant("t2_grant3_seen", n);
    check("t2_third_a", {30'b0, gnt_b, gnt_a}, 2'b01);
    wait_grant("t2_grant4_seen", n);
    check("t2_fourth_b", {30'b0, gnt_b, gnt_a}, 2'b10);
    req_a = 1'b0; req_b = 1'b0;
    wait_done("t2_done");
    check("t2_q_exp", {31'b0, q_exp}, 0);
    check("t2_mismatch", {31'b0, mismatch}, 0);
    tick();

    // ---- Test 3: stuck latch raises mismatch, sticky until next check ----
    stuck = 1'b1;
    req_a = 1'b1; op_a = 1'b1;
    wait_grant("t3_grant", n);
    req_a = 1'b0;
    wait_done("t3_done");
    check("t3_mismatch", {31'b0, mismatch}, 1);
    check("t3_q_exp", {31'b0, q_exp}, 1);
    tick();
    tick();
    check("t3_mismatch_sticky", {31'b0, mismatch}, 1);
    stuck = 1'b0;
    req_b = 1'b1; op_b = 1'b0;
    wait_grant("t3_grant_b", n);
    req_b = 1'b0;
    wait_done("t3_done2");
    check("t3_mismatch_clear", {31'b0, mismatch}, 0);
    check("t3_q_exp2", {31'b0, q_exp}, 0);
    tick();

    // ---- Test 4: reset mid-pulse ----
    req_a = 1'b1; op_a = 1'b1;
    tick();                                   // t0
    check("t4_s_n_t0", {31'b0, s_n}, 0);
    req_a = 1'b0;
    tick();                                   // t0+1
    check("t4_s_n_t1", {31'b0, s_n}, 0);
    rst = 1'b1;
    #1;
    check("t4_s_n_async", {31'b0, s_n}, 1);
    check("t4_busy", {31'b0, busy}, 0);
    check("t4_q_exp", {31'b0, q_exp}, 0);
    tick();
    check("t4_no_done", {31'b0, done}, 0);
    rst = 1'b0;
    tick();
    check("t4_no_done2", {31'b0, done}, 0);
    check("t4_idle", {31'b0, busy}, 0);
    // Last grant before reset was A; a fresh tie must still go to A.
    req_a = 1'b1; op_a = 1'b0; req_b = 1'b1; op_b = 1'b1;
    tick();
    check("t4_prio_a", {30'b0, gnt_b, gnt_a}, 2'b01);
    check("t4_r_n_low", {31'b0, r_n}, 0);
    req_a = 1'b0; req_b = 1'b0;
    wait_done("t4_done");
    check("t4_q_exp_after", {31'b0, q_exp}, 0);
    check("t4_mismatch_after", {31'b0, mismatch}, 0);
    tick();
    tick();

    // ---- Test 5: random traffic under the protocol monitor ----
    run_lo = 0; run_hi = 0; seen_pulse = 1'b0;
    mon_en = 1'b1;
    exp_q = q_exp;
    for (int i = 0; i < 200; i++) begin
      p = $urandom_range(1, 3);
      req_a = p[0]; req_b = p[1];
      op_a = 1'($urandom_range(0, 1));
      op_b = 1'($urandom_range(0, 1));
      n = 0;
      while ((req_a || req_b) && n < 100) begin
        tick();
        n++;
        if (gnt_a) begin exp_q = op_a; req_a = 1'b0; end
        if (gnt_b) begin exp_q = op_b; req_b = 1'b0; end
      end
      check("t5_served", {30'b0, req_b, req_a}, 0);
      req_a = 1'b0; req_b = 1'b0;
    end
    wait_done("t5_done");
    check("t5_q_exp", {31'b0, q_exp}, {31'b0, exp_q});
    check("t5_mismatch", {31'b0, mismatch}, 0);
    tick();
    tick();
    mon_en = 1'b0;

    // ---- Test 6: PULSE_W=1 instance ----
    req_a1 = 1'b1; op_a1 = 1'b1;
    tick();
    check("t6_set_grant", {31'b0, gnt_a1}, 1);
    req_a1 = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!done1 && n < 40);
    check("t6_set_done", {31'b0, done1}, 1);
    check("t6_set_q_exp", {31'b0, q_exp1}, 1);
    tick();
    req_b1 = 1'b1; op_b1 = 1'b0;
    tick();                                   // t0
    check("t6_gnt_b", {31'b0, gnt_b1}, 1);
    check("t6_r_n_t0", {31'b0, r_n1}, 0);
    check("t6_s_n_t0", {31'b0, s_n1}, 1);
    req_b1 = 1'b0;
    tick();                                   // t0+1
    check("t6_r_n_t1", {31'b0, r_n1}, 1);
    tick();                                   // t0+2
    tick();                                   // t0+3
    check("t6_done_early", {31'b0, done1}, 0);
    tick();                                   // t0+4
    check("t6_done", {31'b0, done1}, 1);
    check("t6_q_exp", {31'b0, q_exp1}, 0);
    check("t6_mismatch", {31'b0, mismatch1}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
